// File: rtl/cci_mpf_csr_mgr.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_mgr
// Purpose  : Manager end of the MPF CSR space. Decodes host MMIO writes into
//            shim configuration (VTP mode, page table base, VC map), counts
//            single-cycle shim event pulses, and answers host MMIO reads of
//            configuration, counters and WRO statistics. MMIO reads cannot be
//            back-pressured, so requests are buffered in a small queue and
//            answered one per cycle.
// Ports    : clk, reset_n (async, active low)
//            mmio_wr_*_i  : write strobe / byte address / 64-bit data
//            mmio_rd_*_i  : read strobe / byte address / transaction ID
//            mmio_rsp_*_o : read response strobe / echoed TID / 64-bit data
//            vtp_in_*_o   : VTP mode, page table base (line addr), base valid
//            vc_map_ctrl*_o : VC map control word and its 1-cycle valid pulse
//            vtp_out_event_*_i : event pulses; wro_out_num_*_i : WRO stats
// Options  : CCI_MPF_CSR_EVENT_SAT_EN - event counters saturate instead of
//            wrapping; STATUS bit1 flags that a counter hit saturation.
// Revision : 1.0  initial release
// ============================================================================
module cci_mpf_csr_mgr #(
   parameter int                     MMIO_ADDR_W = 16,
   parameter logic [MMIO_ADDR_W-1:0] CSR_BASE    = '0,
   parameter int                     TID_W       = 9,
   parameter int                     CNT_W       = 48,
   parameter int                     RDQ_DEPTH   = 4,
   parameter int                     MODE_W      = 2,
   parameter int                     CL_ADDR_W   = 42
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   mmio_wr_valid_i,
   input  logic [MMIO_ADDR_W-1:0] mmio_wr_addr_i,
   input  logic [63:0]            mmio_wr_data_i,
   input  logic                   mmio_rd_valid_i,
   input  logic [MMIO_ADDR_W-1:0] mmio_rd_addr_i,
   input  logic [TID_W-1:0]       mmio_rd_tid_i,
   output logic                   mmio_rsp_valid_o,
   output logic [TID_W-1:0]       mmio_rsp_tid_o,
   output logic [63:0]            mmio_rsp_data_o,
   output logic [MODE_W-1:0]      vtp_in_mode_o,
   output logic [CL_ADDR_W-1:0]   vtp_in_page_table_base_o,
   output logic                   vtp_in_page_table_base_valid_o,
   output logic [63:0]            vc_map_ctrl_o,
   output logic                   vc_map_ctrl_valid_o,
   input  logic                   vtp_out_event_4kb_hit_i,
   input  logic                   vtp_out_event_4kb_miss_i,
   input  logic                   vtp_out_event_2mb_hit_i,
   input  logic                   vtp_out_event_2mb_miss_i,
   input  logic                   vtp_out_event_pt_walk_busy_i,
   input  logic [63:0]            wro_out_num_writes_i,
   input  logic [63:0]            wro_out_num_reads_i,
   input  logic [63:0]            wro_out_num_write_conflicts_i,
   input  logic [63:0]            wro_out_num_read_conflicts_i
);

   localparam logic [63:0] CSR_ID    = 64'h4D50_4643_5352_0001;
   localparam int          NUM_EV    = 5;
   localparam int          PTR_W     = $clog2(RDQ_DEPTH);
   localparam logic [3:0]  IDX_STAT  = 4'd13;

   // Decoded register select: {in_window, 8-byte word index}.
   function automatic logic [4:0] decode(input logic [MMIO_ADDR_W-1:0] addr);
      logic [MMIO_ADDR_W-1:0] off;
      logic                   hit;
      off = addr - CSR_BASE;
      hit = (addr >= CSR_BASE) && (off < MMIO_ADDR_W'(112));
      return {hit, off[6:3]};
   endfunction

   logic [4:0] wr_sel, rd_sel;
   logic       wr_en;
   assign wr_sel = decode(mmio_wr_addr_i);
   assign rd_sel = decode(mmio_rd_addr_i);
   assign wr_en  = mmio_wr_valid_i && wr_sel[4];

   logic [NUM_EV-1:0] ev;
   assign ev = {vtp_out_event_pt_walk_busy_i, vtp_out_event_2mb_miss_i,
                vtp_out_event_2mb_hit_i, vtp_out_event_4kb_miss_i,
                vtp_out_event_4kb_hit_i};

   // ---------------- configuration / status registers ----------------
   logic [MODE_W-1:0]    mode_q;
   logic [CL_ADDR_W-1:0] base_q;
   logic                 base_valid_q;
   logic [63:0]          vcmap_q;
   logic                 vcmap_valid_q;
   logic                 ovf_q;
   logic                 stat_wr;
   logic                 rd_drop;
   assign stat_wr = wr_en && (wr_sel[3:0] == IDX_STAT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q        <= '0;
         base_q        <= '0;
         base_valid_q  <= 1'b0;
         vcmap_q       <= '0;
         vcmap_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         vcmap_valid_q <= wr_en && (wr_sel[3:0] == 4'd3);
         if (wr_en && (wr_sel[3:0] == 4'd1)) mode_q <= mmio_wr_data_i[MODE_W-1:0];
         if (wr_en && (wr_sel[3:0] == 4'd2)) begin
            base_q       <= mmio_wr_data_i[CL_ADDR_W-1:0];
            base_valid_q <= 1'b1;
         end
         if (wr_en && (wr_sel[3:0] == 4'd3)) vcmap_q <= mmio_wr_data_i;
         // A drop in the same cycle as a clear must still be recorded.
         if (rd_drop)      ovf_q <= 1'b1;
         else if (stat_wr) ovf_q <= 1'b0;
      end
   end

   // ---------------- event counters ----------------
   logic [CNT_W-1:0] ctr_q [NUM_EV];
   logic [CNT_W-1:0] ctr_d [NUM_EV];
`ifdef CCI_MPF_CSR_EVENT_SAT_EN
   logic             sat_q;
   logic             sat_hit;
`endif

   always_comb begin
`ifdef CCI_MPF_CSR_EVENT_SAT_EN
      sat_hit = 1'b0;
`endif
      for (int i = 0; i < NUM_EV; i++) begin
         ctr_d[i] = ctr_q[i];
         if (wr_en && (wr_sel[3:0] == 4'(4 + i))) begin
            // Clear and event together leave the count at one.
            ctr_d[i] = CNT_W'(ev[i]);
         end else if (ev[i]) begin
`ifdef CCI_MPF_CSR_EVENT_SAT_EN
            if (&ctr_q[i]) sat_hit = 1'b1;
            else           ctr_d[i] = ctr_q[i] + 1'b1;
`else
            ctr_d[i] = ctr_q[i] + 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_EV; i++) ctr_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_EV; i++) ctr_q[i] <= ctr_d[i];
      end
   end

`ifdef CCI_MPF_CSR_EVENT_SAT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     sat_q <= 1'b0;
      else if (sat_hit) sat_q <= 1'b1;
      else if (stat_wr) sat_q <= 1'b0;
   end
`endif

   // ---------------- read request queue ----------------
   logic [4:0]       rdq_sel_q [RDQ_DEPTH];
   logic [TID_W-1:0] rdq_tid_q [RDQ_DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             rdq_deq;
   logic             rdq_enq;

   assign rdq_deq = (cnt_q != '0);
   // A full queue still accepts when its head leaves in the same cycle.
   assign rdq_enq = mmio_rd_valid_i && ((cnt_q != (PTR_W+1)'(RDQ_DEPTH)) || rdq_deq);
   assign rd_drop = mmio_rd_valid_i && !rdq_enq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RDQ_DEPTH; i++) begin
            rdq_sel_q[i] <= '0;
            rdq_tid_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (rdq_enq) begin
            rdq_sel_q[wptr_q] <= rd_sel;
            rdq_tid_q[wptr_q] <= mmio_rd_tid_i;
            wptr_q            <= wptr_q + 1'b1;
         end
         if (rdq_deq) rptr_q <= rptr_q + 1'b1;
         case ({rdq_enq, rdq_deq})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ---------------- read data mux (sampled at dequeue) ----------------
   logic [4:0]  head_sel;
   logic [63:0] head_data;
   logic [63:0] status;

   always_comb begin
      status = 64'(ovf_q);
`ifdef CCI_MPF_CSR_EVENT_SAT_EN
      status[1] = sat_q;
`endif
   end

   assign head_sel = rdq_sel_q[rptr_q];

   always_comb begin
      head_data = '0;
      if (head_sel[4]) begin
         case (head_sel[3:0])
            4'd0:    head_data = CSR_ID;
            4'd1:    head_data = 64'(mode_q);
            4'd2:    head_data = 64'(base_q);
            4'd3:    head_data = vcmap_q;
            4'd4:    head_data = 64'(ctr_q[0]);
            4'd5:    head_data = 64'(ctr_q[1]);
            4'd6:    head_data = 64'(ctr_q[2]);
            4'd7:    head_data = 64'(ctr_q[3]);
            4'd8:    head_data = 64'(ctr_q[4]);
            4'd9:    head_data = wro_out_num_writes_i;
            4'd10:   head_data = wro_out_num_reads_i;
            4'd11:   head_data = wro_out_num_write_conflicts_i;
            4'd12:   head_data = wro_out_num_read_conflicts_i;
            4'd13:   head_data = status;
            default: head_data = '0;
         endcase
      end
   end

   logic             rsp_valid_q;
   logic [TID_W-1:0] rsp_tid_q;
   logic [63:0]      rsp_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rdq_deq;
         if (rdq_deq) begin
            rsp_tid_q  <= rdq_tid_q[rptr_q];
            rsp_data_q <= head_data;
         end
      end
   end

   assign mmio_rsp_valid_o               = rsp_valid_q;
   assign mmio_rsp_tid_o                 = rsp_tid_q;
   assign mmio_rsp_data_o                = rsp_data_q;
   assign vtp_in_mode_o                  = mode_q;
   assign vtp_in_page_table_base_o       = base_q;
   assign vtp_in_page_table_base_valid_o = base_valid_q;
   assign vc_map_ctrl_o                  = vcmap_q;
   assign vc_map_ctrl_valid_o            = vcmap_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_csr_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_csr_mgr
// Purpose  : Scoreboard bench for cci_mpf_csr_mgr. Read requests push their
//            expected {tid, data}; a monitor pops and compares on every
//            response strobe. Configuration outputs are checked directly.
// Revision : 1.0  initial release
// ============================================================================
module tb_cci_mpf_csr_mgr;

   localparam int          TID_W  = 9;
   localparam int          CNT_W  = 8;
   localparam logic [63:0] CSR_ID = 64'h4D50_4643_5352_0001;

   typedef struct packed {
      logic [TID_W-1:0] tid;
      logic [63:0]      data;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             mmio_wr_valid, mmio_rd_valid;
   logic [15:0]      mmio_wr_addr, mmio_rd_addr;
   logic [63:0]      mmio_wr_data;
   logic [TID_W-1:0] mmio_rd_tid;
   logic             rsp_valid;
   logic [TID_W-1:0] rsp_tid;
   logic [63:0]      rsp_data;
   logic [1:0]       mode;
   logic [41:0]      pt_base;
   logic             pt_base_valid;
   logic [63:0]      vc_map;
   logic             vc_map_valid;
   logic [4:0]       ev;
   logic [63:0]      wro_wr, wro_rd, wro_wc, wro_rc;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   rsp_seen = 0;

   always #5 clk = ~clk;

   cci_mpf_csr_mgr #(.CNT_W(CNT_W), .TID_W(TID_W)) dut (
      .clk                            (clk),
      .reset_n                        (reset_n),
      .mmio_wr_valid_i                (mmio_wr_valid),
      .mmio_wr_addr_i                 (mmio_wr_addr),
      .mmio_wr_data_i                 (mmio_wr_data),
      .mmio_rd_valid_i                (mmio_rd_valid),
      .mmio_rd_addr_i                 (mmio_rd_addr),
      .mmio_rd_tid_i                  (mmio_rd_tid),
      .mmio_rsp_valid_o               (rsp_valid),
      .mmio_rsp_tid_o                 (rsp_tid),
      .mmio_rsp_data_o                (rsp_data),
      .vtp_in_mode_o                  (mode),
      .vtp_in_page_table_base_o       (pt_base),
      .vtp_in_page_table_base_valid_o (pt_base_valid),
      .vc_map_ctrl_o                  (vc_map),
      .vc_map_ctrl_valid_o            (vc_map_valid),
      .vtp_out_event_4kb_hit_i        (ev[0]),
      .vtp_out_event_4kb_miss_i       (ev[1]),
      .vtp_out_event_2mb_hit_i        (ev[2]),
      .vtp_out_event_2mb_miss_i       (ev[3]),
      .vtp_out_event_pt_walk_busy_i   (ev[4]),
      .wro_out_num_writes_i           (wro_wr),
      .wro_out_num_reads_i            (wro_rd),
      .wro_out_num_write_conflicts_i  (wro_wc),
      .wro_out_num_read_conflicts_i   (wro_rc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && rsp_valid) begin
            rsp_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rsp: got tid %0d data 0x%0h expected no response", rsp_tid, rsp_data);
            end else begin
               e = exp_q.pop_front();
               if (rsp_tid !== e.tid || rsp_data !== e.data) begin
                  n_fail++;
                  $display("FAIL rsp: got tid %0d data 0x%0h expected tid %0d data 0x%0h",
                           rsp_tid, rsp_data, e.tid, e.data);
               end
            end
         end
      end
   end

   // All drive tasks are entered at a negedge and return at the next one.
   task automatic rd(input logic [15:0] a, input int tid, input logic [63:0] d, input bit push);
      mmio_rd_valid = 1'b1;
      mmio_rd_addr  = a;
      mmio_rd_tid   = TID_W'(tid);
      if (push) exp_q.push_back('{tid: TID_W'(tid), data: d});
      @(negedge clk);
      mmio_rd_valid = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio_wr_valid = 1'b1;
      mmio_wr_addr  = a;
      mmio_wr_data  = d;
      @(negedge clk);
      mmio_wr_valid = 1'b0;
   endtask

   task automatic pulse(input int bit_i, input int n);
      for (int k = 0; k < n; k++) begin
         ev[bit_i] = 1'b1;
         @(negedge clk);
      end
      ev = '0;
   endtask

   task automatic drain();
      int budget = 40;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      int seen0;
      bit sat;
`ifdef CCI_MPF_CSR_EVENT_SAT_EN
      sat = 1'b1;
`else
      sat = 1'b0;
`endif
      reset_n = 1'b0;
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
      mmio_wr_addr = '0; mmio_rd_addr = '0; mmio_wr_data = '0; mmio_rd_tid = '0;
      ev = '0;
      wro_wr = 64'h1111_0000_0000_0001; wro_rd = 64'h2222_0000_0000_0002;
      wro_wc = 64'h0000_0000_0000_0033; wro_rc = 64'hFFFF_FFFF_FFFF_FFF4;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mode", 64'(mode), 64'd0);
      chk("rst_base_valid", 64'(pt_base_valid), 64'd0);
      chk("rst_vc_map", vc_map, 64'd0);
      chk("rst_vc_valid", 64'(vc_map_valid), 64'd0);

      // ID read: request cycle N, response cycle N+2.
      rd(16'h0000, 5, CSR_ID, 1'b1);
      chk("lat_n1", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("lat_n2", 64'(rsp_valid), 64'd1);
      drain();

      wr(16'h0010, 64'h123);
      chk("pt_base", 64'(pt_base), 64'h123);
      chk("pt_base_valid", 64'(pt_base_valid), 64'd1);
      rd(16'h0010, 6, 64'h123, 1'b1);

      wr(16'h0018, 64'hA5);
      chk("vc_map", vc_map, 64'hA5);
      chk("vc_valid_hi", 64'(vc_map_valid), 64'd1);
      @(negedge clk);
      chk("vc_valid_lo", 64'(vc_map_valid), 64'd0);

      wr(16'h0008, 64'hFF);
      chk("mode", 64'(mode), 64'h3);
      rd(16'h000F, 7, 64'h3, 1'b1);          // low address bits ignored
      wr(16'h0000, 64'hDEAD);                // ID is read-only
      rd(16'h0000, 8, CSR_ID, 1'b1);
      wr(16'h0078, 64'h1);
      rd(16'h0070, 9, 64'd0, 1'b1);
      rd(16'h1000, 10, 64'd0, 1'b1);

      // Ten hits, then clear in the same cycle as the eleventh.
      pulse(0, 10);
      ev[0] = 1'b1;
      wr(16'h0020, 64'h0);
      ev = '0;
      rd(16'h0020, 11, 64'd1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         pulse(1, 1);
         @(negedge clk);
      end
      rd(16'h0028, 12, 64'd3, 1'b1);
      pulse(4, 2);
      rd(16'h0040, 13, 64'd2, 1'b1);
      rd(16'h0030, 14, 64'd0, 1'b1);
      rd(16'h0048, 15, wro_wr, 1'b1);
      rd(16'h0050, 16, wro_rd, 1'b1);
      rd(16'h0058, 17, wro_wc, 1'b1);
      rd(16'h0060, 18, wro_rc, 1'b1);

      // Write and read of the same register in one cycle sees the new value.
      mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0018; mmio_wr_data = 64'h5A;
      rd(16'h0018, 19, 64'h5A, 1'b1);
      mmio_wr_valid = 1'b0;
      drain();

      // Six back-to-back reads.
      rd(16'h0000, 30, CSR_ID, 1'b1);
      rd(16'h0010, 31, 64'h123, 1'b1);
      rd(16'h0018, 32, 64'h5A, 1'b1);
      rd(16'h0020, 33, 64'd1, 1'b1);
      rd(16'h0048, 34, wro_wr, 1'b1);
      rd(16'h0008, 35, 64'h3, 1'b1);
      drain();

      // Stall dequeue: four reads fill the queue, two more are dropped.
      force dut.rdq_deq = 1'b0;
      for (int k = 0; k < 6; k++) rd(16'h0000, 40 + k, CSR_ID, k < 4);
      release dut.rdq_deq;
      drain();
      rd(16'h0068, 46, 64'd1, 1'b1);
      drain();

      // Counter at maximum, then one more event.
      pulse(3, (1 << CNT_W) - 1);
      rd(16'h0038, 47, 64'hFF, 1'b1);
      pulse(3, 1);
      rd(16'h0038, 48, sat ? 64'hFF : 64'd0, 1'b1);
      rd(16'h0068, 49, sat ? 64'd3 : 64'd1, 1'b1);
      wr(16'h0068, 64'h0);
      rd(16'h0068, 50, 64'd0, 1'b1);
      drain();

      // Reset with reads queued: none may be answered.
      force dut.rdq_deq = 1'b0;
      rd(16'h0000, 60, CSR_ID, 1'b0);
      rd(16'h0000, 61, CSR_ID, 1'b0);
      seen0 = rsp_seen;
      reset_n = 1'b0;
      @(negedge clk);
      release dut.rdq_deq;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_no_rsp", 64'(rsp_seen - seen0), 64'd0);
      chk("rst2_base_valid", 64'(pt_base_valid), 64'd0);
      chk("rst2_vc_map", vc_map, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
